// File: rtl/sha2_pkg.sv
// Shared constants, state encoding and parameter checks for the SHA-2 message schedule.
package sha2_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Small-sigma rotate/shift amounts, 32-bit words (SHA-224/256)
    localparam int S0_ROT_A_32 = 7;
    localparam int S0_ROT_B_32 = 18;
    localparam int S0_SHR_32   = 3;
    localparam int S1_ROT_A_32 = 17;
    localparam int S1_ROT_B_32 = 19;
    localparam int S1_SHR_32   = 10;

    // Small-sigma rotate/shift amounts, 64-bit words (SHA-384/512)
    localparam int S0_ROT_A_64 = 1;
    localparam int S0_ROT_B_64 = 8;
    localparam int S0_SHR_64   = 7;
    localparam int S1_ROT_A_64 = 19;
    localparam int S1_ROT_B_64 = 61;
    localparam int S1_SHR_64   = 6;

    function automatic bit is_wide_mode(input int mode);
        return (mode == 384) || (mode == 512);
    endfunction

    function automatic int rounds_for(input int mode);
        return is_wide_mode(mode) ? 80 : 64;
    endfunction

    function automatic bit mode_legal(input int mode, input int width);
        return (((mode == 224) || (mode == 256)) && (width == 32)) ||
               (((mode == 384) || (mode == 512)) && (width == 64));
    endfunction

endpackage

// File: rtl/sha2_msg_schedule_if.sv
// Block-in / word-out handshake bundle of the message schedule.
interface sha2_msg_schedule_if #(parameter int WIDTH = 32);
    logic [16*WIDTH-1:0] block_in;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    w_out;
    logic [6:0]          w_idx;
    logic                w_valid;
    logic                w_ready;
    logic                w_last;

    modport slave (
        input  block_in, in_valid, w_ready,
        output in_ready, w_out, w_idx, w_valid, w_last
    );

    modport master (
        output block_in, in_valid, w_ready,
        input  in_ready, w_out, w_idx, w_valid, w_last
    );
endinterface

// File: rtl/sha2_small_sigma.sv
// Combinational SHA-2 small sigma; SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha2_small_sigma
    import sha2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = 256,
    parameter int SEL   = 0
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);
    localparam bit WIDE = is_wide_mode(MODE);
    localparam int RA = (SEL == 0) ? (WIDE ? S0_ROT_A_64 : S0_ROT_A_32)
                                   : (WIDE ? S1_ROT_A_64 : S1_ROT_A_32);
    localparam int RB = (SEL == 0) ? (WIDE ? S0_ROT_B_64 : S0_ROT_B_32)
                                   : (WIDE ? S1_ROT_B_64 : S1_ROT_B_32);
    localparam int SH = (SEL == 0) ? (WIDE ? S0_SHR_64 : S0_SHR_32)
                                   : (WIDE ? S1_SHR_64 : S1_SHR_32);

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
        return (v >> n) | (v << (WIDTH - n));
    endfunction

    assign y = rotr(x, RA) ^ rotr(x, RB) ^ (x >> SH);
endmodule

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: loads one block, then streams W_0..W_{ROUNDS-1}
// from a 16-word sliding window, extending it by one word per handshake.
module sha2_msg_schedule
    import sha2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    sha2_msg_schedule_if.slave    bus
);
    localparam int         ROUNDS = rounds_for(MODE);
    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    if (!mode_legal(MODE, WIDTH)) begin : g_illegal_mode
        $error("sha2_msg_schedule: illegal MODE/WIDTH combination");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] window [16];
    logic [6:0]       t;
    logic [WIDTH-1:0] s0, s1;
    logic             load, fire;

    assign load = (state == IDLE) && bus.in_valid;
    assign fire = (state == RUN) && bus.w_ready;

    sha2_small_sigma #(.WIDTH(WIDTH), .MODE(MODE), .SEL(0)) u_sigma0 (.x(window[1]),  .y(s0));
    sha2_small_sigma #(.WIDTH(WIDTH), .MODE(MODE), .SEL(1)) u_sigma1 (.x(window[14]), .y(s1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = RUN;
            RUN:  if (bus.w_ready && (t == LAST_T)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t <= '0;
            for (int i = 0; i < 16; i++) window[i] <= '0;
        end else if (load) begin
            t <= '0;
            for (int i = 0; i < 16; i++) window[i] <= bus.block_in[(16-i)*WIDTH-1 -: WIDTH];
        end else if (fire) begin
            // Words generated past ROUNDS-16 land in the window but are never emitted.
            for (int i = 0; i < 15; i++) window[i] <= window[i+1];
            window[15] <= s1 + window[9] + s0 + window[0];
            t <= (t == LAST_T) ? 7'd0 : t + 7'd1;
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.w_valid  = (state == RUN);
    assign bus.w_out    = (state == RUN) ? window[0] : '0;
    assign bus.w_idx    = t;
    assign bus.w_last   = (state == RUN) && (t == LAST_T);
endmodule

// File: doc/sha2_msg_schedule.md
Name: sha2_msg_schedule

Overview:
- Message-schedule stage directly upstream of the SHA-2 round datapath.
- Accepts one padded 512/1024-bit message block and produces the round word W_t, one per handshake, for t = 0..ROUNDS-1.
- The round controller pairs each W_t with its K_t and feeds both to the compression round.
- Holds a 16-word sliding window and computes W_{t+16} on the fly; no 64/80-word storage.

Parameters:
- WIDTH, 32, word width. Must be 32 for MODE 224/256 and 64 for MODE 384/512.
- MODE, 256, SHA-2 variant: 224, 256, 384 or 512. Any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- block_in  in  16*WIDTH  message block. Word 0 is block_in[16*WIDTH-1 -: WIDTH]; word 15 is bits [WIDTH-1:0].
- in_valid  in  1  block_in is valid.
- in_ready  out  1  stage is idle and can accept a block.
- w_out  out  WIDTH  current schedule word W_t.
- w_idx  out  7  current round index t.
- w_valid  out  1  w_out and w_idx are valid.
- w_ready  in  1  consumer accepts w_out this cycle.
- w_last  out  1  asserted with w_valid when t == ROUNDS-1.

Behaviour:
- ROUNDS = 64 for MODE 224/256; 80 for MODE 384/512.
- Reset (synchronous, clk edge with rst=1): state IDLE, window[0..15]=0, t=0. Outputs then read in_ready=1, w_valid=0, w_last=0, w_out=0, w_idx=0.
- rst has priority over every other input. Reset mid-block abandons the block; no partial words are emitted afterwards.
- FSM states: IDLE and RUN.
- IDLE:
  - in_ready=1, w_valid=0.
  - On in_valid: window[i] <= word i of block_in, t <= 0, next state RUN. in_valid is ignored while in RUN.
- RUN:
  - in_ready=0, w_valid=1, w_out=window[0], w_idx=t. All outputs are registered or derived directly from registers, with no combinational path from w_ready.
  - On w_valid&w_ready:
    - window[i] <= window[i+1] for i=0..14.
    - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^WIDTH, with carries discarded.
    - t <= t+1.
  - w_ready=0: all state holds. w_out and w_idx stay stable while waiting.
  - Handshake at t == ROUNDS-1: next state IDLE, t <= 0.
- Latency:
  - Block accepted at edge N → W_0 valid in the cycle after edge N.
  - With w_ready held high, one word per cycle.
  - in_ready returns high the cycle after the last handshake.
  - Back-to-back blocks: minimum one IDLE cycle between blocks.
- w_out is forced to 0 whenever w_valid=0.
- sigma0/sigma1, MODE 224/256:
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10.
- sigma0/sigma1, MODE 384/512:
  - sigma0 = ROTR1 ^ ROTR8 ^ SHR7.
  - sigma1 = ROTR19 ^ ROTR61 ^ SHR6.
- Window values computed beyond t = ROUNDS-16 are discarded. They are never exposed after the last word.

Decomposition:
- Package sha2_pkg holds:
  - ROUNDS per MODE.
  - Rotate/shift constants for sigma0/sigma1 for both word sizes.
  - The state enum {IDLE, RUN}.
  - A MODE/WIDTH legality check function.
- One sub-module, sha2_small_sigma (params WIDTH, MODE, SEL: 0 selects sigma0, 1 selects sigma1). It is purely combinational and is instantiated twice.

Test Plan:
- MODE 256, "abc" block (word0=0x61626380, words 1..14=0, word15=0x00000018), w_ready=1:
  - W_0=0x61626380, W_16=0x61626380, W_17=0x000F0000, W_63=0x12B1EDEB.
  - w_last only at w_idx=63.
  - in_ready=1 one cycle later.
- MODE 512, "abc" block (word0=0x6162638000000000, word15=0x18):
  - W_16=0x6162638000000000, W_17=0x00030000000000C0.
  - 80 words emitted, w_last at w_idx=79.
- All-zero block, MODE 256: all 64 words are 0. Then a new block is accepted while in_valid is held high continuously, and it is captured only after the IDLE cycle.
- Backpressure with the "abc" block: w_ready toggles 1,0,0,1 pseudo-randomly.
  - Word sequence is identical to the unstalled run.
  - w_out and w_idx are stable during stalls.
  - Total handshakes = 64.
- Reset at w_idx=20 during RUN:
  - Next cycle: w_valid=0, w_out=0, in_ready=1.
  - A fresh "abc" load again yields W_0=0x61626380, W_17=0x000F0000.
- in_valid pulsed with a different block during RUN: ignored, and the output sequence is unchanged.
